// File: rtl/fir_pkg.sv
// Shared FIR definitions: tap delay line state encoding, default sample width
// and the helper that places a tap on the flat tap bus.
package fir_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2,
        FLUSH = 2'd3
    } tap_dl_state_e;

    localparam int SAMPLE_W_DEF = 16;

    // LSB position of tap k on a bus of w-bit taps (tap 0 at the bottom).
    function automatic int tap_lsb(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/dflop_sr.sv
// W-bit enable flop with synchronous active-high reset; one stage of the
// tap delay line.
module dflop_sr #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_q <= '0;
        end else if (en_i) begin
            r_q <= d_i;
        end
    end

    assign q_o = r_q;

endmodule

// File: rtl/tap_delay_line.sv
// DEPTH-stage tapped sample history with valid/ready input, fill tracking and
// a full-window strobe. Define TAP_DELAY_LINE_FLUSH_EN to add the zero-flush.
module tap_delay_line
    import fir_pkg::*;
#(
    parameter int W     = SAMPLE_W_DEF,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [W-1:0]       data_i,
`ifdef TAP_DELAY_LINE_FLUSH_EN
    input  logic               flush_i,
`endif
    output logic [DEPTH*W-1:0] taps_o,
    output logic [W-1:0]       data_o,
    output logic               out_valid_o,
    output logic [CNT_W-1:0]   fill_o,
    output logic               full_o
);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_M1 = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

    tap_dl_state_e           r_state, w_state_nxt;
    logic [CNT_W-1:0]        r_fill, w_fill_nxt;
    logic [CNT_W-1:0]        r_fcnt, w_fcnt_nxt;
    logic                    r_out_valid;
    logic                    w_flush_req;
    logic                    w_ready;
    logic                    w_accept;
    logic                    w_shift;
    logic [W-1:0]            w_tap_d0;
    logic [DEPTH-1:0][W-1:0] w_taps;

`ifdef TAP_DELAY_LINE_FLUSH_EN
    // A flush request blocks the same-cycle sample before the state changes.
    assign w_flush_req = en_i && flush_i && (r_state != FLUSH);
    assign w_ready     = (r_state != FLUSH) && !flush_i;
`else
    assign w_flush_req = 1'b0;
    assign w_ready     = 1'b1;
`endif

    assign w_accept = en_i && in_valid_i && w_ready;
    assign w_shift  = w_accept || (en_i && (r_state == FLUSH));
    assign w_tap_d0 = (r_state == FLUSH) ? '0 : data_i;

    always_comb begin
        w_state_nxt = r_state;
        w_fill_nxt  = r_fill;
        w_fcnt_nxt  = r_fcnt;
        if (en_i) begin
            case (r_state)
                FLUSH: begin
                    if (r_fcnt == '0) begin
                        w_state_nxt = EMPTY;
                    end else begin
                        w_fcnt_nxt = r_fcnt - ONE_C;
                    end
                end
                default: begin
                    if (w_flush_req) begin
                        w_state_nxt = FLUSH;
                        w_fill_nxt  = '0;
                        w_fcnt_nxt  = DEPTH_M1;
                    end else if (w_accept) begin
                        if (r_fill != DEPTH_C) begin
                            w_fill_nxt = r_fill + ONE_C;
                        end
                        w_state_nxt = (w_fill_nxt == DEPTH_C) ? FULL : FILL;
                    end
                end
            endcase
        end
    end

    // The strobe is recomputed every edge so it always drops after one cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= EMPTY;
            r_fill      <= '0;
            r_fcnt      <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_fill      <= w_fill_nxt;
            r_fcnt      <= w_fcnt_nxt;
            r_out_valid <= w_accept && (r_fill >= DEPTH_M1);
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_tap
        logic [W-1:0] w_stage_d;
        if (k == 0) begin : g_head
            assign w_stage_d = w_tap_d0;
        end else begin : g_body
            assign w_stage_d = w_taps[k-1];
        end
        dflop_sr #(.W(W)) u_stage (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .en_i  (w_shift),
            .d_i   (w_stage_d),
            .q_o   (w_taps[k])
        );
        assign taps_o[tap_lsb(k, W) +: W] = w_taps[k];
    end

    assign data_o      = w_taps[DEPTH-1];
    assign in_ready_o  = w_ready;
    assign fill_o      = r_fill;
    assign full_o      = (r_fill == DEPTH_C);
    assign out_valid_o = r_out_valid;

endmodule

// File: tb/tb_tap_delay_line.sv
// Scoreboard bench for tap_delay_line (W=16, DEPTH=4): a queue-based history
// model predicts every cycle; a monitor compares after each rising edge.
module tb_tap_delay_line;

    localparam int W     = 16;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en = 1'b0;
    logic               vld = 1'b0;
    logic [W-1:0]       data = '0;
    logic               flush = 1'b0;
    logic               in_ready;
    logic [DEPTH*W-1:0] taps;
    logic [W-1:0]       dout;
    logic               out_valid;
    logic [CNT_W-1:0]   fill;
    logic               full;

    always #5 clk = ~clk;

    tap_delay_line #(.W(W), .DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .in_valid_i  (vld),
        .in_ready_o  (in_ready),
        .data_i      (data),
`ifdef TAP_DELAY_LINE_FLUSH_EN
        .flush_i     (flush),
`endif
        .taps_o      (taps),
        .data_o      (dout),
        .out_valid_o (out_valid),
        .fill_o      (fill),
        .full_o      (full)
    );

    typedef struct packed {
        logic [DEPTH*W-1:0] taps;
        logic [W-1:0]       dout;
        logic [CNT_W-1:0]   fill;
        logic               full;
        logic               ov;
        logic               rdy;
    } st_t;

    st_t                sq[$];
    logic [DEPTH*W-1:0] wq[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] m_hist[$];
    int           m_fill = 0;
    int           m_flush_left = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hist = {};
        repeat (DEPTH) m_hist.push_back('0);
        m_fill = 0;
        m_flush_left = 0;
    endtask

    task automatic shift_in(input logic [W-1:0] x);
        m_hist.push_front(x);
        void'(m_hist.pop_back());
    endtask

    // Drive one cycle of stimulus and record what must be seen after the edge.
    task automatic cycle(input logic r, input logic e, input logic v,
                         input logic [W-1:0] d, input logic f);
        st_t  s;
        logic ready, acc, ov;
        logic fl;
        fl = f;
`ifndef TAP_DELAY_LINE_FLUSH_EN
        fl = 1'b0;
`endif
        @(negedge clk);
        rst = r; en = e; vld = v; data = d; flush = fl;
        ov = 1'b0;
        if (r) begin
            model_reset();
        end else begin
            ready = (m_flush_left == 0) && !fl;
            acc   = e && v && ready;
            ov    = acc && (m_fill >= DEPTH - 1);
            if (e) begin
                if (m_flush_left > 0) begin
                    shift_in('0);
                    m_flush_left--;
                end else if (fl) begin
                    m_fill = 0;
                    m_flush_left = DEPTH;
                end else if (acc) begin
                    shift_in(d);
                    if (m_fill < DEPTH) m_fill++;
                end
            end
        end
        for (int k = 0; k < DEPTH; k++) s.taps[k*W +: W] = m_hist[k];
        s.dout = m_hist[DEPTH-1];
        s.fill = CNT_W'(m_fill);
        s.full = (m_fill == DEPTH);
        s.ov   = ov;
        s.rdy  = (m_flush_left == 0) && !fl;
        sq.push_back(s);
        if (ov) wq.push_back(s.taps);
    endtask

    initial begin : monitor
        st_t s;
        forever begin
            @(posedge clk);
            #1;
            if (sq.size() > 0) begin
                s = sq.pop_front();
                chk("taps", 64'(taps), 64'(s.taps));
                chk("data_o", 64'(dout), 64'(s.dout));
                chk("fill", 64'(fill), 64'(s.fill));
                chk("full", 64'(full), 64'(s.full));
                chk("out_valid", 64'(out_valid), 64'(s.ov));
                chk("in_ready", 64'(in_ready), 64'(s.rdy));
                if (out_valid === 1'b1) begin
                    if (wq.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL window: actual=strobe required=no strobe at %0t", $time);
                    end else begin
                        chk("window", 64'(taps), 64'(wq.pop_front()));
                    end
                end
            end
        end
    end

    initial begin : stimulus
        model_reset();
        repeat (3) cycle(1, 1, 0, '0, 0);

        for (int i = 1; i <= 4; i++) cycle(0, 1, 1, W'(i), 0);
        @(posedge clk); #2;
        chk("spot_window_1234", 64'(taps), {16'd1, 16'd2, 16'd3, 16'd4});
        chk("spot_full", 64'(full), 64'd1);

        cycle(0, 1, 1, 16'd5, 0);
        cycle(0, 1, 1, 16'd6, 0);
        @(posedge clk); #2;
        chk("spot_data_o_after_6", 64'(dout), 64'd3);
        cycle(0, 1, 0, 16'd99, 0);
        repeat (5) cycle(0, 0, 1, 16'h7777, 0);
        cycle(0, 1, 1, 16'd7, 0);
        cycle(0, 1, 0, '0, 0);

        cycle(0, 1, 1, 16'h1111, 0);
        repeat (3) cycle(1, 1, 1, 16'h2222, 0);
        cycle(0, 1, 0, '0, 0);

`ifdef TAP_DELAY_LINE_FLUSH_EN
        for (int i = 0; i < 4; i++) cycle(0, 1, 1, 16'h00A0 + W'(i), 0);
        cycle(0, 1, 1, 16'hDEAD, 1);
        @(posedge clk); #2;
        chk("spot_flush_fill", 64'(fill), 64'd0);
        for (int i = 0; i < DEPTH; i++) cycle(0, 1, 1, W'($urandom), 0);
        @(posedge clk); #2;
        chk("spot_flushed_taps", 64'(taps), 64'd0);
        cycle(0, 1, 1, 16'h0042, 0);

        for (int i = 0; i < 4; i++) cycle(0, 1, 1, 16'h00B0 + W'(i), 0);
        cycle(0, 1, 0, '0, 1);
        cycle(0, 1, 0, '0, 0);
        cycle(0, 1, 0, '0, 0);
        cycle(1, 1, 0, '0, 0);
        cycle(0, 1, 1, 16'hABCD, 0);
        @(posedge clk); #2;
        chk("spot_after_flush_reset", 64'(taps), 64'h0000_0000_0000_ABCD);
        chk("spot_fill_one", 64'(fill), 64'd1);
`endif

        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(99, 0) < 2,
                  $urandom_range(99, 0) < 85,
                  $urandom_range(99, 0) < 70,
                  W'($urandom),
                  $urandom_range(99, 0) < 4);
        end

        repeat (2) cycle(0, 1, 0, '0, 0);
        @(posedge clk); #2;
        chk("scoreboard_drained", 64'(wq.size() + sq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tap_delay_line.md
# tap_delay_line

Parametrised W-bit, DEPTH-stage tapped delay line with per-stage enable, valid/ready input handshake, fill tracking and optional zero-flush. It generalises the single enable flop into the sample history register that feeds the FIR multiply-accumulate datapath. Every stage is visible on a flat tap bus, and a one-cycle strobe marks each new full window.

## Interface
- W, 16, sample width in bits (>=1)
- DEPTH, 8, number of stages / taps (>=2)
- CNT_W, $clog2(DEPTH+1), derived width of fill count; not overridden
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-high
- en_i  in  1  global enable; low freezes all state (taps, FSM, counters)
- in_valid_i  in  1  data_i carries a sample
- in_ready_o  out  1  block can accept; = (state != FLUSH) && !flush_i (flush_i term only with macro)
- data_i  in  W  input sample
- flush_i  in  1  request zero-flush (present only with macro)
- taps_o  out  DEPTH*W  tap k at [k*W +: W]; tap 0 newest
- data_o  out  W  oldest tap (tap DEPTH-1)
- out_valid_o  out  1  one-cycle strobe: window full and just updated
- fill_o  out  CNT_W  accepted samples held, saturates at DEPTH
- full_o  out  1  fill_o == DEPTH

## Operation
- Accept = en_i && in_valid_i && in_ready_o. On accept: tap0 <= data_i, tap k <= tap k-1, fill_o += 1 saturating at DEPTH.
- No accept: taps and fill hold; no bubble inserted.
- FSM: EMPTY (fill 0) -> FILL on accept; FILL -> FULL when accept brings fill to DEPTH; FULL stays FULL on accept; FLUSH described below.
- DEPTH==... special case: with fill DEPTH-1 a single accept goes FILL -> FULL.
- out_valid_o registered: next cycle high iff accept occurred with fill_o >= DEPTH-1 before the edge; low otherwise. Pulse is not gated by en_i on the falling side (drops after one cycle even if en_i goes low).
- Flush (macro only): flush_i with en_i high and state != FLUSH -> FLUSH; fill_o and full_o cleared to 0 on that edge; flush counter loaded DEPTH-1. Each en_i cycle in FLUSH shifts zero into tap0; counter decrements; after DEPTH zero shifts total state = EMPTY with all taps zero. in_valid_i ignored during FLUSH; out_valid_o held low. flush_i asserted while in FLUSH has no effect.
- Simultaneous flush_i and in_valid_i: flush wins, sample not accepted (in_ready_o low that cycle).
- Reset (any state, including mid-flush): all taps 0, fill_o 0, full_o 0, out_valid_o 0, state EMPTY, flush counter 0. Reset overrides en_i.

## Timing
- Latency data_i -> tap0: 1 cycle after accept; -> data_o: DEPTH accepts.
- out_valid_o: 1 cycle after the accepting edge that completes/updates a full window; coincides with taps_o showing that window.
- fill_o, full_o, in_ready_o (state term) registered; in_ready_o has combinational path from flush_i only.
- Flush duration: DEPTH cycles with en_i high; en_i low stretches it.
- Reset values: taps_o 0, data_o 0, out_valid_o 0, fill_o 0, full_o 0, in_ready_o 1.

## Configuration
- TAP_DELAY_LINE_FLUSH_EN defined: flush_i port, FLUSH state and flush counter present as above.
- Undefined: no flush_i port; FSM is EMPTY/FILL/FULL only; in_ready_o tied 1; history cleared only by rst_i.

## Structure
- Shared package fir_pkg: state enum tap_dl_state_e {EMPTY, FILL, FULL, FLUSH}, default sample width constant, tap-index helper function.
- Sub-module dflop_sr: W-bit enable flop with synchronous active-high reset, instantiated DEPTH times by generate; control FSM and counters in the top.

## Test plan
- Reset: hold rst_i 3 cycles mid-stream -> all outputs at reset values, in_ready_o 1.
- Fill, W=16 DEPTH=4: accept 1,2,3,4 consecutively -> fill_o 1..4, full_o after 4th edge, taps_o {tap3..tap0}={1,2,3,4}, out_valid_o single pulse next cycle.
- Streaming: accept 5 then 6 while full -> data_o 2 then 3, out_valid_o high each following cycle; idle cycle -> out_valid_o 0, taps hold.
- Stall: en_i low 5 cycles with in_valid_i high -> no state change, no pulse; resume -> next sample shifts normally.
- Flush (macro): full window, flush_i with in_valid_i=1 same cycle -> sample dropped, in_ready_o 0 for 4 cycles, taps all 0, state EMPTY, no out_valid_o.
- Reset during flush at cycle 2 of 4 -> EMPTY, taps 0, next accept lands in tap0 with fill_o 1.
